icache_dm: RTL and testbench

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/icache_dm.sv | 77 +++++++
 tb/tb_icache_dm.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the instruction-cache address split.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ITAG_W  = 26;
    localparam int IIDX_W  = 4;
    localparam int IBYT_W  = 2;
    localparam int IFRAMES = 16;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped 16 x 1-word instruction cache; hits answer combinationally in the same cycle.
// A miss stalls the datapath (ihit = 0) until memory drops iwait, then the fill lands and IDLE resumes.
module icache_dm
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q;
    icachef_t          miss_q;
    logic              valid_q [IFRAMES];
    logic [ITAG_W-1:0] tag_q   [IFRAMES];
    word_t             data_q  [IFRAMES];

    logic [ITAG_W-1:0] req_tag;
    logic [IIDX_W-1:0] req_idx;
    logic              hit;
    logic              fill;

    assign req_tag = imemaddr[31:IIDX_W+IBYT_W];
    assign req_idx = imemaddr[IIDX_W+IBYT_W-1:IBYT_W];

    assign hit  = (state_q == IDLE) && imemREN && valid_q[req_idx]
                  && (tag_q[req_idx] == req_tag);
    assign fill = (state_q == FETCH) && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? data_q[req_idx] : '0;
    assign iREN     = (state_q == FETCH);
    assign iaddr    = iREN ? word_t'(miss_q) : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            miss_q  <= '0;
            for (int i = 0; i < IFRAMES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit) begin
                        miss_q  <= icachef_t'(imemaddr);
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        valid_q[miss_q.idx] <= 1'b1;
                        state_q             <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data need no reset: a frame is only trusted once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_q.idx]  <= miss_q.tag;
            data_q[miss_q.idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a reference model predicts outputs per cycle, a monitor compares them.
module tb_icache_dm;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iwait;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;

    icache_dm dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iwait    (iwait),
        .iload    (iload),
        .iREN     (iREN),
        .iaddr    (iaddr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic        hit;
        logic [31:0] load;
        logic        ren;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic        m_fetch;
    logic [31:0] m_miss;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic m_hit();
        logic [3:0] idx;
        idx = imemaddr[5:2];
        return !RST && !m_fetch && imemREN && m_valid[idx] && (m_tag[idx] == imemaddr[31:6]);
    endfunction

    task automatic m_reset();
        m_fetch = 1'b0;
        m_miss  = '0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic m_update();
        logic [3:0] fidx;
        if (RST) begin
            m_reset();
        end else if (!m_fetch) begin
            if (imemREN && !m_hit()) begin
                m_miss  = imemaddr;
                m_fetch = 1'b1;
            end
        end else if (!iwait) begin
            fidx          = m_miss[5:2];
            m_valid[fidx] = 1'b1;
            m_tag[fidx]   = m_miss[31:6];
            m_data[fidx]  = iload;
            m_fetch       = 1'b0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        logic h;
        h      = m_hit();
        e.hit  = h;
        e.load = h ? m_data[imemaddr[5:2]] : 32'h0;
        e.ren  = !RST && m_fetch;
        e.addr = (!RST && m_fetch) ? m_miss : 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic ren, input logic [31:0] addr,
                        input logic w, input logic [31:0] ld);
        @(posedge CLK);
        m_update();
        #1;
        RST      = rst;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = w;
        iload    = ld;
        if (rst) m_reset();
        push_exp();
    endtask

    // Detection cycle, n_wait busy cycles, then the fill cycle.
    task automatic miss_fill(input logic [31:0] addr, input int n_wait, input logic [31:0] data);
        step(1'b0, 1'b1, addr, 1'b1, 32'h0);
        for (int i = 0; i < n_wait; i++) step(1'b0, 1'b1, addr, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, addr, 1'b0, data);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ihit",     32'(ihit), 32'(e.hit));
            chk("imemload", imemload,  e.load);
            chk("iREN",     32'(iREN), 32'(e.ren));
            chk("iaddr",    iaddr,     e.addr);
        end
    end

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        m_reset();
        for (int i = 0; i < 16; i++) begin
            m_tag[i]  = '0;
            m_data[i] = '0;
        end

        // Reset held, then released with requests idle
        step(1'b1, 1'b1, 32'h40, 1'b0, 32'h1234);
        #1 chk("rst_iREN", 32'(iREN), 32'h0);
        step(1'b0, 1'b0, 32'h40, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h80, 1'b0, 32'h0);

        // Cold miss on 0x40 with three busy cycles
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        #1 chk("cold_detect_iREN", 32'(iREN), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
            #1 chk("cold_fetch_iaddr", iaddr, 32'h40);
        end
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h8C01_0004);
        #1 chk("cold_fill_iREN", 32'(iREN), 32'h1);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        #1 chk("cold_hit_data", imemload, 32'h8C01_0004);

        // Idle gap then hit again
        step(1'b0, 1'b0, 32'h40, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        #1 chk("rehit_ihit", 32'(ihit), 32'h1);
        #0 chk("rehit_iREN", 32'(iREN), 32'h0);

        // Conflict on index 0
        miss_fill(32'h80, 1, 32'hAAAA_0080);
        step(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
        #1 chk("conflict_hit80", imemload, 32'hAAAA_0080);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        #1 chk("conflict_miss40", 32'(ihit), 32'h0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h8C01_0004);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);

        // Address change mid-fetch
        step(1'b0, 1'b1, 32'h44, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h100, 1'b1, 32'h0);
        #1 chk("chg_iaddr", iaddr, 32'h44);
        step(1'b0, 1'b0, 32'h100, 1'b0, 32'h4444_0044);
        step(1'b0, 1'b1, 32'h100, 1'b1, 32'h0);
        #1 chk("chg_newmiss", 32'(ihit), 32'h0);
        step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0100_0100);
        #1 chk("chg_iaddr100", iaddr, 32'h100);
        step(1'b0, 1'b1, 32'h44, 1'b1, 32'h0);
        #1 chk("chg_hit44", imemload, 32'h4444_0044);

        // Reset during fetch
        step(1'b0, 1'b1, 32'h200, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h200, 1'b1, 32'h0);
        step(1'b1, 1'b1, 32'h200, 1'b0, 32'h5555_5555);
        #1 chk("rstfetch_iREN", 32'(iREN), 32'h0);
        step(1'b0, 1'b0, 32'h200, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h44, 1'b1, 32'h0);
        #1 chk("rstfetch_miss44", 32'(ihit), 32'h0);
        step(1'b0, 1'b1, 32'h44, 1'b0, 32'h4444_0044);

        // Byte offset ignored
        miss_fill(32'h48, 2, 32'h4848_0048);
        step(1'b0, 1'b1, 32'h4B, 1'b1, 32'h0);
        #1 chk("bytoff_hit", 32'(ihit), 32'h1);
        #0 chk("bytoff_data", imemload, 32'h4848_0048);

        // Random traffic over a small address pool to exercise conflicts
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00};
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) != 0), a,
                 ($urandom_range(0, 2) != 0), $urandom);
        end

        @(posedge CLK);
        @(negedge CLK);
        #1 chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
